// File: rtl/mem_stage_sram_ctrl_pkg.sv
// mem_stage_sram_ctrl_pkg: shared widths, data base address and FSM state encodings
package mem_stage_sram_ctrl_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int DATA_BASE = 1024;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACCESS = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: fixed-latency async SRAM access controller that stalls the pipeline
module mem_stage_sram_ctrl #(
  parameter int WORD_WIDTH = mem_stage_sram_ctrl_pkg::WORD_WIDTH,
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int DATA_BASE = mem_stage_sram_ctrl_pkg::DATA_BASE,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       MEM_R_EN,
  input  logic                       MEM_W_EN,
  input  logic [WORD_WIDTH-1:0]      ALU_Res,
  input  logic [WORD_WIDTH-1:0]      Val_Rm,
  output logic                       ready,
  output logic [WORD_WIDTH-1:0]      read_data,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0]      sram_wdata,
  input  logic [WORD_WIDTH-1:0]      sram_rdata,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
);
  import mem_stage_sram_ctrl_pkg::*;
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
  state_t state;
  logic [3:0] cnt;
  logic op_w;
  logic req;
  assign req = MEM_R_EN | MEM_W_EN;
  // Stall upstream while a request is pending or in flight; DONE releases it for one cycle
  assign ready = (state == IDLE) ? ~req : (state == DONE);
  // Strobes follow the state directly so a reset drops them without waiting for a clock
  assign sram_we_n = !(state == ACCESS && op_w);
  assign sram_oe_n = !(state == ACCESS && !op_w);
  // Access FSM: latch the request, count the wait cycles, capture load data on the last one
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      op_w <= 1'b0;
      read_data <= '0;
      sram_addr <= '0;
      sram_wdata <= '0;
    end else
      case (state)
        IDLE: if (req) begin
          state <= ACCESS;
          cnt <= '0;
          op_w <= MEM_W_EN;
          sram_addr <= SRAM_ADDR_WIDTH'((ALU_Res - WORD_WIDTH'(DATA_BASE)) >> 2);
          sram_wdata <= Val_Rm;
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            state <= DONE;
            if (!op_w) read_data <= sram_rdata;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: directed self-checking bench with a behavioural async SRAM
module tb_mem_stage_sram_ctrl;
  logic clk, rst, MEM_R_EN, MEM_W_EN, ready, sram_we_n, sram_oe_n;
  logic [31:0] ALU_Res, Val_Rm, read_data, sram_wdata, sram_rdata;
  logic [17:0] sram_addr;
  logic [31:0] mem [0:262143];
  int checks = 0, errors = 0, we_cyc = 0, oe_cyc = 0, w0, o0;

  mem_stage_sram_ctrl dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .ready(ready), .read_data(read_data),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  assign sram_rdata = mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr] <= sram_wdata;
      we_cyc <= we_cyc + 1;
    end
    if (!sram_oe_n) oe_cyc <= oe_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [17:0] ea, input string tag);
    logic exp_we, exp_oe;
    exp_we = !w;
    exp_oe = !(r && !w);
    @(negedge clk);
    MEM_R_EN = r;
    MEM_W_EN = w;
    ALU_Res = a;
    Val_Rm = d;
    #1;
    chk({tag, "_c0_ready"}, 32'(ready), 32'd0);
    chk({tag, "_c0_we_n"}, 32'(sram_we_n), 32'd1);
    chk({tag, "_c0_oe_n"}, 32'(sram_oe_n), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1;
      chk({tag, "_acc_ready"}, 32'(ready), 32'd0);
      chk({tag, "_acc_we_n"}, 32'(sram_we_n), 32'(exp_we));
      chk({tag, "_acc_oe_n"}, 32'(sram_oe_n), 32'(exp_oe));
      chk({tag, "_acc_addr"}, 32'(sram_addr), 32'(ea));
      if (w) chk({tag, "_acc_wdata"}, sram_wdata, d);
    end
    @(negedge clk);
    #1;
    chk({tag, "_done_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done_we_n"}, 32'(sram_we_n), 32'd1);
    chk({tag, "_done_oe_n"}, 32'(sram_oe_n), 32'd1);
  endtask

  initial begin
    rst = 0;
    MEM_R_EN = 0;
    MEM_W_EN = 0;
    ALU_Res = 0;
    Val_Rm = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_wdata", sram_wdata, 32'd0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_we_n", 32'(sram_we_n), 32'd1);
      chk("idle_oe_n", 32'(sram_oe_n), 32'd1);
      chk("idle_read_data", read_data, 32'd0);
    end
    w0 = we_cyc;
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd2, "st");
    chk("st_read_data", read_data, 32'd0);
    @(negedge clk);
    MEM_W_EN = 0;
    #1;
    chk("st_after_ready", 32'(ready), 32'd1);
    chk("st_we_cycles", 32'(we_cyc - w0), 32'd4);
    chk("st_mem2", mem[2], 32'hDEADBEEF);
    o0 = oe_cyc;
    access(1'b1, 1'b0, 32'd1032, 32'h0, 18'd2, "ld");
    chk("ld_read_data", read_data, 32'hDEADBEEF);
    @(negedge clk);
    MEM_R_EN = 0;
    #1;
    chk("ld_after_ready", 32'(ready), 32'd1);
    @(negedge clk);
    #1;
    chk("ld_oe_cycles", 32'(oe_cyc - o0), 32'd4);
    access(1'b0, 1'b1, 32'd1024, 32'h12345678, 18'd0, "b2b_st");
    access(1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, "b2b_ld");
    chk("b2b_read_data", read_data, 32'h12345678);
    chk("b2b_mem0", mem[0], 32'h12345678);
    w0 = we_cyc;
    @(negedge clk);
    MEM_R_EN = 1;
    MEM_W_EN = 0;
    ALU_Res = 32'd1032;
    @(negedge clk);
    #1;
    chk("rstm_acc1_oe_n", 32'(sram_oe_n), 32'd0);
    @(negedge clk);
    #1;
    chk("rstm_acc2_oe_n", 32'(sram_oe_n), 32'd0);
    rst = 0;
    #1;
    chk("rstm_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rstm_we_n", 32'(sram_we_n), 32'd1);
    chk("rstm_read_data", read_data, 32'd0);
    MEM_R_EN = 0;
    #1;
    chk("rstm_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rstm_post_ready", 32'(ready), 32'd1);
      chk("rstm_post_oe_n", 32'(sram_oe_n), 32'd1);
    end
    chk("rstm_no_write", 32'(we_cyc - w0), 32'd0);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, "pre");
    chk("pre_read_data", read_data, 32'h12345678);
    $display("note: both enables set (illegal encoding), expecting a store");
    access(1'b1, 1'b1, 32'd1020, 32'hCAFEF00D, 18'h3FFFF, "both");
    chk("both_read_data", read_data, 32'h12345678);
    chk("both_mem_wrap", mem[18'h3FFFF], 32'hCAFEF00D);
    @(negedge clk);
    MEM_R_EN = 0;
    MEM_W_EN = 0;
    #1;
    chk("end_ready", 32'(ready), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory-stage access controller sitting directly downstream of the EXE/MEM pipeline register. It consumes the registered memory-read/write enables, the ALU result (byte address) and the Rm value (store data), and performs a fixed-latency access to an external asynchronous SRAM. It holds the pipeline by deasserting `ready` until the access completes, then presents load data to the MEM/WB register.

## Interface
- `WORD_WIDTH`, 32, data/address word width
- `SRAM_ADDR_WIDTH`, 18, SRAM word-address width
- `DATA_BASE`, 1024, byte address mapped to SRAM word 0
- `WAIT_CYCLES`, 4, SRAM access cycles (legal 1..15)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `MEM_R_EN`  in  1  load request from EXE/MEM register
- `MEM_W_EN`  in  1  store request from EXE/MEM register
- `ALU_Res`  in  WORD_WIDTH  byte address
- `Val_Rm`  in  WORD_WIDTH  store data
- `ready`  out  1  0 = freeze all upstream pipeline registers and PC
- `read_data`  out  WORD_WIDTH  load result, valid in DONE cycle and held after
- `sram_addr`  out  SRAM_ADDR_WIDTH  SRAM word address
- `sram_wdata`  out  WORD_WIDTH  SRAM write data
- `sram_rdata`  in  WORD_WIDTH  SRAM read data
- `sram_we_n`  out  1  SRAM write strobe, active-low
- `sram_oe_n`  out  1  SRAM output enable, active-low

## Operation
- FSM states: IDLE, ACCESS, DONE; wait counter `cnt`, 4 bits.
- IDLE: `req = MEM_R_EN | MEM_W_EN`. If req: latch `sram_addr`, `sram_wdata <= Val_Rm`, latch op (write if `MEM_W_EN`), `cnt <= 0`, go to ACCESS. Otherwise stay.
- ACCESS: `sram_we_n = 0` for write, `sram_oe_n = 0` for read; `cnt` increments each cycle. When `cnt == WAIT_CYCLES-1`: read → `read_data <= sram_rdata`; go to DONE.
- DONE: one cycle, then IDLE unconditionally. Enables are still asserted because upstream is frozen; DONE prevents re-issue of the same request.
- `ready` is combinational: IDLE → `~req`; ACCESS → 0; DONE → 1.
- Address: `sram_addr = (ALU_Res - DATA_BASE)[SRAM_ADDR_WIDTH+1:2]`. Unsigned subtract, bits [1:0] dropped, upper bits truncated. No range check: out-of-range addresses wrap modulo SRAM size.
- `MEM_R_EN` and `MEM_W_EN` both set: treated as write, and `read_data` is unchanged. This is an illegal encoding, and the bench flags it.
- Stores never modify `read_data`.
- `sram_we_n`/`sram_oe_n` are 1 in IDLE and DONE. `sram_addr`/`sram_wdata` hold their last value outside ACCESS.

## Timing
- Reset (`rst` = 0, asynchronous): state IDLE, `cnt` 0, `read_data` 0, `sram_addr` 0, `sram_wdata` 0, op = read, `sram_we_n` 1, `sram_oe_n` 1.
- During reset, `ready` = `~req` (IDLE).
- Reset mid-ACCESS: strobes deassert immediately and the access is abandoned. No retry.
- Request seen in cycle 0 → `ready` low in cycles 0..WAIT_CYCLES (WAIT_CYCLES+1 stall cycles) → `ready` high in cycle WAIT_CYCLES+1 (DONE).
- Load data is valid from cycle WAIT_CYCLES+1.
- No request: `ready` stays 1 and there is zero overhead.
- Back-to-back memory ops: the next request is seen in the cycle after DONE (IDLE), with no bubble beyond the stall itself.
- Strobes are asserted for exactly WAIT_CYCLES cycles per access.

## Structure
- The shared constants header supplies `WORD_WIDTH`, the default `DATA_BASE`, and the state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2).
- No sub-module. Single file: FSM, counter, registered address/data/op, and a combinational `ready` and strobes.
- An SRAM behavioural model (zero-delay array, asynchronous read) lives in the bench only.

## Test plan
1. Reset release with enables low → `ready` = 1, `sram_we_n` = `sram_oe_n` = 1, `read_data` = 0, for 10 cycles.
2. Store with `ALU_Res` = 1032, `Val_Rm` = 0xDEADBEEF, WAIT_CYCLES = 4:
   - `sram_addr` = 2, `sram_we_n` low for exactly 4 cycles.
   - `ready` low for 5 cycles, then high for 1 cycle.
   - Model word 2 = 0xDEADBEEF.
3. Load from 1032 following test 2:
   - `sram_oe_n` low for 4 cycles.
   - `read_data` = 0xDEADBEEF in the DONE cycle.
   - Exactly one access is issued although the enables are held through DONE.
4. Back-to-back store to 1024 then load from 1024, both holding enables:
   - Two distinct 5-cycle stalls separated only by DONE/IDLE.
   - Second access reads the stored value.
5. `rst` pulled low in the 2nd ACCESS cycle:
   - Strobes go to 1 asynchronously, `read_data` = 0.
   - After release with enables low, `ready` = 1 and no SRAM write has occurred.
6. `ALU_Res` = 1020 (below base) → `sram_addr` = 2^18−1 (wrap). Both enables set → write performed, `read_data` unchanged.
